// File: rtl/serial_rx.sv
// serial_rx: 8N1 LSB-first serial receiver with framing-error and break handling
module serial_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, s1_q, rxd_s;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      s1_q    <= 1'b1;
      rxd_s   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      s1_q    <= rxd;
      rxd_s   <= s1_q;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d   = '0;
        sh_d    = {rxd_s, sh_q[7:1]};
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == FULL) begin
        cnt_d   = '0;
        valid_d = rxd_s;
        ferr_d  = !rxd_s;
        data_d  = rxd_s ? sh_q : data_q;
        state_d = rxd_s ? IDLE : BRK;
      end
      BRK: begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : BRK;
      end
      default: state_d = IDLE;
    endcase
  end
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench for serial_rx with directed frames
module tb_serial_rx;
  localparam int N = 16;
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1;
  logic [7:0] data;
  logic valid, frame_err, busy;
  int cyc = 0, vecs = 0, errs = 0;
  logic [7:0] last = 8'h00;
  typedef struct {logic [7:0] d; logic err; int c;} exp_t;
  exp_t q[$];
  serial_rx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data),
    .valid(valid), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (valid || frame_err)) begin
      vecs++;
      if (valid && frame_err) begin
        errs++;
        $display("FAIL both_strobes cyc=%0d valid=%b frame_err=%b", cyc, valid, frame_err);
      end else if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_strobe cyc=%0d valid=%b frame_err=%b data=%h", cyc, valid, frame_err, data);
      end else begin
        e = q.pop_front();
        if (frame_err !== e.err || data !== e.d || cyc != e.c || busy !== e.err) begin
          errs++;
          $display("FAIL strobe got err=%b data=%h cyc=%0d busy=%b, want err=%b data=%h cyc=%0d busy=%b",
                   frame_err, data, cyc, busy, e.err, e.d, e.c, e.err);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    exp_t e;
    e.d   = stop ? b : last;
    e.err = !stop;
    e.c   = cyc + 155;
    q.push_back(e);
    if (stop) last = b;
    rxd = 1'b0;
    repeat (N) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (N) tick();
    end
    rxd = stop;
    repeat (N) tick();
  endtask
  initial begin
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_ferr", {7'd0, frame_err}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    tick();
    repeat (100) tick();
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_data", data, 8'h00);
    send_frame(8'hA5, 1'b1);
    repeat (N) tick();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (N) tick();
    send_frame(8'h55, 1'b0);
    repeat (40) tick();
    chk("break_busy_hi", {7'd0, busy}, 8'd1);
    rxd = 1'b1;
    repeat (4) tick();
    chk("break_busy_lo", {7'd0, busy}, 8'd0);
    chk("break_data", data, 8'hFF);
    send_frame(8'h81, 1'b1);
    repeat (2 * N) tick();
    rxd = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 5) rxd = 1'b1;
      @(negedge clk);
      chk($sformatf("glitch_busy_%0d", i), {7'd0, busy}, {7'd0, i >= 3 && i <= 10});
      #1;
    end
    repeat (N) tick();
    send_frame(8'h0F, 1'b1);
    repeat (N) tick();
    rxd = 1'b0;
    repeat (N) tick();
    for (int i = 0; i < 4; i++) begin
      rxd = i[0] ? 1'b1 : 1'b0;
      repeat (N) tick();
    end
    rxd = 1'b0;
    repeat (N / 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rxd = 1'b1;
    last = 8'h00;
    @(negedge clk);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_valid", {7'd0, valid}, 8'd0);
    chk("mid_rst_ferr", {7'd0, frame_err}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    tick();
    repeat (2 * N) tick();
    send_frame(8'hC3, 1'b1);
    for (int i = 0; i < 2000 && q.size() != 0; i++) tick();
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    repeat (2 * N) tick();
    chk("final_data", data, 8'hC3);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
